uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex 8N1 UART with a FIFO on each direction, used as the serial peripheral behind a simple register-style host interface.
- The host pushes TX bytes and pops RX bytes using toggle-style request lines, so every level change is one request.
- Bit timing is a runtime clock divider.

Parameters:
- FIFO_DEPTH, 64, entries in each of the TX and RX FIFOs; must be a power of two, at least 2.
- RX_ENABLE, 1, 0 removes the receiver. Outputs then become: uart_rx_ready=0, uart_rx_byte=0.
- TX_ENABLE, 1, 0 removes the transmitter. Outputs then become: uart_tx_pin=1, uart_tx_fifo_empty=1, uart_tx_fifo_full=0.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- baud_div  in  16  clocks per bit (F_CLK/BAUD); values below 4 are treated as 4.
- uart_tx_start  in  1  toggle; each level change requests a push of uart_tx_data_in.
- uart_tx_data_in  in  8  byte to push.
- uart_tx_pin  out  1  serial output, idle high.
- uart_tx_fifo_full  out  1  TX occupancy == FIFO_DEPTH.
- uart_tx_fifo_empty  out  1  TX occupancy == 0.
- uart_rx_pin  in  1  serial input, asynchronous.
- uart_rx_read  in  1  toggle; each level change requests a pop into uart_rx_byte.
- uart_rx_ready  out  1  RX FIFO not empty.
- uart_rx_byte  out  8  registered last-popped byte.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Both FIFOs are emptied and all FSMs go idle.
  - Outputs: uart_tx_pin=1, uart_tx_fifo_empty=1, uart_tx_fifo_full=0, uart_rx_ready=0, uart_rx_byte=0.
  - The toggle-history registers load the current levels of uart_tx_start and uart_rx_read, so reset never creates a request.
  - Reset mid-frame aborts the frame immediately.
- Request detect: a request fires at the first clk edge where an input differs from its history register. The history register updates on that same edge. At most one request per line per clock.
- TX push:
  - On request, if not full, uart_tx_data_in is written at the tail and occupancy increments; full/empty are valid on the next cycle.
  - If full, the byte is silently dropped.
- TX engine:
  - FSM states: IDLE → START → DATA → STOP → IDLE.
  - Leaves IDLE when the FIFO is non-empty, reading the head without popping it; baud_div is latched at frame start.
  - Line sequence: start bit 0, then 8 data bits LSB first, then stop bit 1; each bit lasts baud_div clocks.
  - The head is popped at the end of the stop bit. The byte in flight therefore counts toward occupancy, and 64 pushes fill the FIFO even while transmitting.
  - Back-to-back frames have no idle gap.
  - A simultaneous push and pop keeps occupancy unchanged.
- RX engine:
  - uart_rx_pin passes through a 2-flop synchronizer.
  - FSM states: IDLE → START → DATA → STOP.
  - In IDLE, a falling edge starts a frame; the line is re-checked at baud_div/2 and a 1 there returns to IDLE as a glitch.
  - Data bits are sampled every baud_div clocks at mid-bit, LSB first.
  - Stop sample: if 1, the byte is pushed to the RX FIFO; if 0 (framing error), the byte is discarded. Either way the FSM returns to IDLE after the stop-bit sample.
  - RX FIFO full: the new byte is dropped.
- RX pop:
  - On request, if non-empty, the head is loaded into uart_rx_byte on that edge and popped; uart_rx_ready updates the next cycle.
  - If empty, nothing happens and uart_rx_byte holds its value (0 after reset).
  - A simultaneous push and pop is supported.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full and empty are derived from the pointers and are registered or glitch-free.

Test Plan:
- Reset release, clk 50 MHz, baud_div=434 → uart_tx_fifo_empty=1, uart_tx_fifo_full=0, uart_rx_ready=0, uart_tx_pin=1.
- Idle pop: toggle uart_rx_read with the RX FIFO empty → uart_rx_ready stays 0, uart_rx_byte=0x00.
- Loopback (uart_tx_pin→uart_rx_pin):
  - Push 48 bytes 0x01..0x30, one every 2 clocks, then wait 48*15*434 clocks.
  - Then 48 pops return 0x01..0x30 in order, each preceded by uart_rx_ready=1.
- Overflow: push 80 bytes 0x01..0x50.
  - uart_tx_fifo_full=1 after the 64th push and stays 1 through the 80th.
  - After draining, exactly 64 bytes 0x01..0x40 are received, and uart_rx_ready=0 afterwards.
- Frame timing: push 0xA5 → low start bit for 434 clocks, then bits 1,0,1,0,0,1,0,1 (LSB first), then a high stop bit of 434 clocks each.
- Framing error / glitch:
  - Drive a 100-clock low pulse on uart_rx_pin → no byte is received.
  - Drive a frame with stop bit 0 → the byte is discarded and uart_rx_ready stays 0.
  - After either case, the end state is uart_tx_fifo_empty=1, uart_tx_fifo_full=0, uart_rx_ready=0.

Source files
------------

// File: rtl/uart_core_if.sv
// Host-side bundle for uart_core: baud setting, toggle request lines, FIFO
// status, the registered RX byte and the two serial pins.
interface uart_core_if;
    logic [15:0] baud_div;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_pin;
    logic        uart_tx_fifo_full;
    logic        uart_tx_fifo_empty;
    logic        uart_rx_pin;
    logic        uart_rx_read;
    logic        uart_rx_ready;
    logic [7:0]  uart_rx_byte;

    modport master (
        output baud_div, uart_tx_start, uart_tx_data_in, uart_rx_pin, uart_rx_read,
        input  uart_tx_pin, uart_tx_fifo_full, uart_tx_fifo_empty, uart_rx_ready, uart_rx_byte
    );

    modport slave (
        input  baud_div, uart_tx_start, uart_tx_data_in, uart_rx_pin, uart_rx_read,
        output uart_tx_pin, uart_tx_fifo_full, uart_tx_fifo_empty, uart_rx_ready, uart_rx_byte
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with a FIFO per direction and toggle-style host requests.
// Bit time is baud_div clocks (minimum 4), latched at the start of every frame.
module uart_core #(
    parameter int FIFO_DEPTH = 64,
    parameter bit RX_ENABLE  = 1'b1,
    parameter bit TX_ENABLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_core_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic [15:0] baud_eff;
    logic        tx_pin;
    logic        tx_full;
    logic        tx_empty;
    logic        rx_ready;
    logic [7:0]  rx_byte;

    assign baud_eff               = (bus.baud_div < 16'd4) ? 16'd4 : bus.baud_div;
    assign bus.uart_tx_pin        = tx_pin;
    assign bus.uart_tx_fifo_full  = tx_full;
    assign bus.uart_tx_fifo_empty = tx_empty;
    assign bus.uart_rx_ready      = rx_ready;
    assign bus.uart_rx_byte       = rx_byte;

    generate
        if (TX_ENABLE) begin : g_tx
            logic [7:0]    tx_mem [FIFO_DEPTH];
            logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_rd_inc;
            logic          tx_full_q, tx_full_d, tx_empty_q, tx_empty_d;
            logic          tx_hist_q, tx_hist_d;
            logic          tx_pin_q, tx_pin_d;
            logic          tx_push, tx_pop;
            tx_state_e     tx_state_q, tx_state_d;
            logic [15:0]   tx_cnt_q, tx_cnt_d, tx_baud_q, tx_baud_d;
            logic [2:0]    tx_bit_q, tx_bit_d;
            logic [7:0]    tx_shift_q, tx_shift_d;

            always_comb begin
                tx_hist_d  = bus.uart_tx_start;
                tx_push    = (bus.uart_tx_start != tx_hist_q) && !tx_full_q;
                tx_pop     = 1'b0;
                tx_rd_inc  = tx_rd_q + PW'(1);
                tx_state_d = tx_state_q;
                tx_cnt_d   = tx_cnt_q;
                tx_baud_d  = tx_baud_q;
                tx_bit_d   = tx_bit_q;
                tx_shift_d = tx_shift_q;

                case (tx_state_q)
                    TX_IDLE: begin
                        if (!tx_empty_q) begin
                            tx_state_d = TX_START;
                            tx_baud_d  = baud_eff;
                            tx_cnt_d   = baud_eff - 16'd1;
                            tx_shift_d = tx_mem[tx_rd_q[AW-1:0]];
                        end
                    end
                    TX_START: begin
                        if (tx_cnt_q == 16'd0) begin
                            tx_state_d = TX_DATA;
                            tx_cnt_d   = tx_baud_q - 16'd1;
                            tx_bit_d   = 3'd0;
                        end else begin
                            tx_cnt_d = tx_cnt_q - 16'd1;
                        end
                    end
                    TX_DATA: begin
                        if (tx_cnt_q == 16'd0) begin
                            tx_cnt_d   = tx_baud_q - 16'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            if (tx_bit_q == 3'd7) begin
                                tx_state_d = TX_STOP;
                            end else begin
                                tx_bit_d = tx_bit_q + 3'd1;
                            end
                        end else begin
                            tx_cnt_d = tx_cnt_q - 16'd1;
                        end
                    end
                    TX_STOP: begin
                        if (tx_cnt_q == 16'd0) begin
                            // Pop the byte just sent; chain straight into the next one if queued
                            tx_pop = 1'b1;
                            if (tx_wr_q != tx_rd_inc) begin
                                tx_state_d = TX_START;
                                tx_baud_d  = baud_eff;
                                tx_cnt_d   = baud_eff - 16'd1;
                                tx_shift_d = tx_mem[tx_rd_inc[AW-1:0]];
                            end else begin
                                tx_state_d = TX_IDLE;
                            end
                        end else begin
                            tx_cnt_d = tx_cnt_q - 16'd1;
                        end
                    end
                    default: tx_state_d = TX_IDLE;
                endcase

                tx_wr_d    = tx_wr_q + PW'(tx_push);
                tx_rd_d    = tx_rd_q + PW'(tx_pop);
                tx_empty_d = (tx_wr_d == tx_rd_d);
                tx_full_d  = (tx_wr_d[AW-1:0] == tx_rd_d[AW-1:0]) && (tx_wr_d[AW] != tx_rd_d[AW]);

                case (tx_state_d)
                    TX_START: tx_pin_d = 1'b0;
                    TX_DATA:  tx_pin_d = tx_shift_d[0];
                    default:  tx_pin_d = 1'b1;
                endcase
            end

            always_ff @(posedge clk) begin
                tx_hist_q <= tx_hist_d;
                if (!rst_n) begin
                    tx_wr_q    <= '0;
                    tx_rd_q    <= '0;
                    tx_full_q  <= 1'b0;
                    tx_empty_q <= 1'b1;
                    tx_pin_q   <= 1'b1;
                    tx_state_q <= TX_IDLE;
                    tx_cnt_q   <= 16'd0;
                    tx_baud_q  <= 16'd4;
                    tx_bit_q   <= 3'd0;
                    tx_shift_q <= 8'd0;
                end else begin
                    tx_wr_q    <= tx_wr_d;
                    tx_rd_q    <= tx_rd_d;
                    tx_full_q  <= tx_full_d;
                    tx_empty_q <= tx_empty_d;
                    tx_pin_q   <= tx_pin_d;
                    tx_state_q <= tx_state_d;
                    tx_cnt_q   <= tx_cnt_d;
                    tx_baud_q  <= tx_baud_d;
                    tx_bit_q   <= tx_bit_d;
                    tx_shift_q <= tx_shift_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n && tx_push) begin
                    tx_mem[tx_wr_q[AW-1:0]] <= bus.uart_tx_data_in;
                end
            end

            assign tx_pin   = tx_pin_q;
            assign tx_full  = tx_full_q;
            assign tx_empty = tx_empty_q;
        end else begin : g_no_tx
            assign tx_pin   = 1'b1;
            assign tx_full  = 1'b0;
            assign tx_empty = 1'b1;
        end
    endgenerate

    generate
        if (RX_ENABLE) begin : g_rx
            logic [7:0]    rx_mem [FIFO_DEPTH];
            logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
            logic          rx_full_q, rx_full_d, rx_empty_q, rx_empty_d;
            logic          rx_hist_q, rx_hist_d;
            logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
            logic          rx_push, rx_pop;
            rx_state_e     rx_state_q, rx_state_d;
            logic [15:0]   rx_cnt_q, rx_cnt_d, rx_baud_q, rx_baud_d;
            logic [2:0]    rx_bit_q, rx_bit_d;
            logic [7:0]    rx_shift_q, rx_shift_d;
            logic [7:0]    rx_byte_q, rx_byte_d;

            always_comb begin
                // s1/s2 synchronize the pin; s3 only serves start-edge detection
                rx_s1_d    = bus.uart_rx_pin;
                rx_s2_d    = rx_s1_q;
                rx_s3_d    = rx_s2_q;
                rx_hist_d  = bus.uart_rx_read;
                rx_pop     = (bus.uart_rx_read != rx_hist_q) && !rx_empty_q;
                rx_push    = 1'b0;
                rx_state_d = rx_state_q;
                rx_cnt_d   = rx_cnt_q;
                rx_baud_d  = rx_baud_q;
                rx_bit_d   = rx_bit_q;
                rx_shift_d = rx_shift_q;

                case (rx_state_q)
                    RX_IDLE: begin
                        if (rx_s3_q && !rx_s2_q) begin
                            rx_state_d = RX_START;
                            rx_baud_d  = baud_eff;
                            rx_cnt_d   = (baud_eff >> 1) - 16'd1;
                        end
                    end
                    RX_START: begin
                        if (rx_cnt_q == 16'd0) begin
                            if (rx_s2_q) begin
                                rx_state_d = RX_IDLE;
                            end else begin
                                rx_state_d = RX_DATA;
                                rx_cnt_d   = rx_baud_q - 16'd1;
                                rx_bit_d   = 3'd0;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt_q - 16'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt_q == 16'd0) begin
                            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                            rx_cnt_d   = rx_baud_q - 16'd1;
                            if (rx_bit_q == 3'd7) begin
                                rx_state_d = RX_STOP;
                            end else begin
                                rx_bit_d = rx_bit_q + 3'd1;
                            end
                        end else begin
                            rx_cnt_d = rx_cnt_q - 16'd1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_cnt_q == 16'd0) begin
                            rx_state_d = RX_IDLE;
                            rx_push    = rx_s2_q && !rx_full_q;
                        end else begin
                            rx_cnt_d = rx_cnt_q - 16'd1;
                        end
                    end
                    default: rx_state_d = RX_IDLE;
                endcase

                rx_wr_d    = rx_wr_q + PW'(rx_push);
                rx_rd_d    = rx_rd_q + PW'(rx_pop);
                rx_empty_d = (rx_wr_d == rx_rd_d);
                rx_full_d  = (rx_wr_d[AW-1:0] == rx_rd_d[AW-1:0]) && (rx_wr_d[AW] != rx_rd_d[AW]);
                rx_byte_d  = rx_pop ? rx_mem[rx_rd_q[AW-1:0]] : rx_byte_q;
            end

            always_ff @(posedge clk) begin
                rx_hist_q <= rx_hist_d;
                if (!rst_n) begin
                    rx_s1_q    <= 1'b1;
                    rx_s2_q    <= 1'b1;
                    rx_s3_q    <= 1'b1;
                    rx_wr_q    <= '0;
                    rx_rd_q    <= '0;
                    rx_full_q  <= 1'b0;
                    rx_empty_q <= 1'b1;
                    rx_state_q <= RX_IDLE;
                    rx_cnt_q   <= 16'd0;
                    rx_baud_q  <= 16'd4;
                    rx_bit_q   <= 3'd0;
                    rx_shift_q <= 8'd0;
                    rx_byte_q  <= 8'd0;
                end else begin
                    rx_s1_q    <= rx_s1_d;
                    rx_s2_q    <= rx_s2_d;
                    rx_s3_q    <= rx_s3_d;
                    rx_wr_q    <= rx_wr_d;
                    rx_rd_q    <= rx_rd_d;
                    rx_full_q  <= rx_full_d;
                    rx_empty_q <= rx_empty_d;
                    rx_state_q <= rx_state_d;
                    rx_cnt_q   <= rx_cnt_d;
                    rx_baud_q  <= rx_baud_d;
                    rx_bit_q   <= rx_bit_d;
                    rx_shift_q <= rx_shift_d;
                    rx_byte_q  <= rx_byte_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n && rx_push) begin
                    rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
                end
            end

            assign rx_ready = !rx_empty_q;
            assign rx_byte  = rx_byte_q;
        end else begin : g_no_rx
            assign rx_ready = 1'b0;
            assign rx_byte  = 8'd0;
        end
    endgenerate
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-timing vector table, loopback,
// TX overflow, hand-driven RX frames (valid, glitch, framing error) and resets.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int DEPTH = 64;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    logic [7:0] exp_q[$];

    uart_core_if bus();
    assign bus.uart_rx_pin = loop_en ? bus.uart_tx_pin : rx_drv;

    uart_core #(.FIFO_DEPTH(DEPTH), .RX_ENABLE(1'b1), .TX_ENABLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] baud;
        logic [7:0]  data;
        int          period;
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        @(posedge clk); #1;
        bus.uart_tx_data_in = b;
        bus.uart_tx_start   = ~bus.uart_tx_start;
        if (accept) exp_q.push_back(b);
        @(posedge clk); #1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp_b;
        chk({name, "_ready"}, 32'(bus.uart_rx_ready), 32'd1);
        @(posedge clk); #1;
        bus.uart_rx_read = ~bus.uart_rx_read;
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb actual=%02h required=none", name, bus.uart_rx_byte);
        end else begin
            exp_b = exp_q.pop_front();
            chk(name, 32'(bus.uart_rx_byte), 32'(exp_b));
        end
        $display("pop %s byte=%02h", name, bus.uart_rx_byte);
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_tx_empty(input string name, input int limit);
        int n = 0;
        while (bus.uart_tx_fifo_empty !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.uart_tx_fifo_empty), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] data, input logic stop, input int p);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            rx_drv = bits[k];
            repeat (p - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        rx_drv = 1'b1;
    endtask

    initial begin
        vecs[0] = '{baud: 16'd434, data: 8'hA5, period: 434};
        vecs[1] = '{baud: 16'd16,  data: 8'h3B, period: 16};
        vecs[2] = '{baud: 16'd1,   data: 8'hC3, period: 4};
        vecs[3] = '{baud: 16'd4,   data: 8'h81, period: 4};
        vecs[4] = '{baud: 16'd5,   data: 8'h7E, period: 5};

        bus.baud_div        = 16'd434;
        bus.uart_tx_start   = 1'b0;
        bus.uart_tx_data_in = 8'h00;
        bus.uart_rx_read    = 1'b0;

        // Reset: toggling request lines while in reset must not create requests
        apply_reset(5);
        chk("rst_tx_empty", 32'(bus.uart_tx_fifo_empty), 32'd1);
        chk("rst_tx_full",  32'(bus.uart_tx_fifo_full),  32'd0);
        chk("rst_rx_ready", 32'(bus.uart_rx_ready),      32'd0);
        chk("rst_tx_pin",   32'(bus.uart_tx_pin),        32'd1);
        chk("rst_rx_byte",  32'(bus.uart_rx_byte),       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.uart_tx_start = 1'b1;
        bus.uart_rx_read  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_toggle_tx_empty", 32'(bus.uart_tx_fifo_empty), 32'd1);
        chk("rst_toggle_tx_pin",   32'(bus.uart_tx_pin),        32'd1);

        // Idle pop on an empty RX FIFO
        @(posedge clk); #1;
        bus.uart_rx_read = ~bus.uart_rx_read;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_pop_ready", 32'(bus.uart_rx_ready), 32'd0);
        chk("idle_pop_byte",  32'(bus.uart_rx_byte),  32'd0);
        $display("idle pop byte=%02h", bus.uart_rx_byte);

        // Frame timing table, with loopback so each frame is also received
        loop_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            logic [9:0] bits;
            int n;
            int bad;
            bus.baud_div = vecs[v].baud;
            push_byte(vecs[v].data, 1'b1);
            n = 0;
            while (bus.uart_tx_pin !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("frame%0d_start", v), 32'(bus.uart_tx_pin), 32'd0);
            bits = {1'b1, vecs[v].data, 1'b0};
            for (int k = 0; k < 10; k++) begin
                bad = 0;
                for (int j = 0; j < vecs[v].period; j++) begin
                    if (!(k == 0 && j == 0)) @(negedge clk);
                    if (bus.uart_tx_pin !== bits[k]) bad++;
                end
                chk($sformatf("frame%0d_slot%0d_badsamples", v, k), 32'(bad), 32'd0);
            end
            $display("frame %0d baud=%0d data=%02h", v, vecs[v].baud, vecs[v].data);
            repeat (4 * vecs[v].period) @(negedge clk);
            pop_check($sformatf("frame%0d_rx", v));
            chk($sformatf("frame%0d_ready_after", v), 32'(bus.uart_rx_ready), 32'd0);
        end

        // Loopback: 48 bytes
        bus.baud_div = 16'd16;
        for (int i = 1; i <= 48; i++) push_byte(8'(i), 1'b1);
        wait_tx_empty("loop_tx_drained", 48 * 10 * 16 + 500);
        repeat (20 * 16) @(negedge clk);
        for (int i = 1; i <= 48; i++) pop_check($sformatf("loop%0d", i));
        chk("loop_ready_after", 32'(bus.uart_rx_ready), 32'd0);

        // Overflow: 80 pushes, the byte in flight still occupies a slot
        bus.baud_div = 16'd32;
        for (int i = 1; i <= 80; i++) begin
            push_byte(8'(i), i <= DEPTH);
            chk($sformatf("ovf_full%0d", i), 32'(bus.uart_tx_fifo_full), 32'(i >= DEPTH));
            if (i == 1) chk("ovf_not_empty", 32'(bus.uart_tx_fifo_empty), 32'd0);
        end
        wait_tx_empty("ovf_tx_drained", DEPTH * 10 * 32 + 1000);
        chk("ovf_full_after", 32'(bus.uart_tx_fifo_full), 32'd0);
        repeat (20 * 32) @(negedge clk);
        for (int i = 1; i <= DEPTH; i++) pop_check($sformatf("ovf%0d", i));
        chk("ovf_ready_after", 32'(bus.uart_rx_ready), 32'd0);

        // Hand-driven RX frames
        loop_en = 1'b0;
        bus.baud_div = 16'd434;
        drive_frame(8'h5A, 1'b1, 434);
        repeat (2 * 434) @(negedge clk);
        exp_q.push_back(8'h5A);
        pop_check("manual_rx");

        @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        chk("glitch_ready", 32'(bus.uart_rx_ready), 32'd0);
        $display("glitch pulse 100 clocks");

        drive_frame(8'h96, 1'b0, 434);
        repeat (2 * 434) @(negedge clk);
        chk("framing_ready", 32'(bus.uart_rx_ready), 32'd0);
        chk("end_tx_empty",  32'(bus.uart_tx_fifo_empty), 32'd1);
        chk("end_tx_full",   32'(bus.uart_tx_fifo_full),  32'd0);
        $display("framing error frame data=96");

        // Reset in the middle of a TX frame
        push_byte(8'h00, 1'b0);
        repeat (1000) @(negedge clk);
        chk("midframe_pin_low", 32'(bus.uart_tx_pin), 32'd0);
        apply_reset(2);
        chk("midframe_rst_pin",   32'(bus.uart_tx_pin),        32'd1);
        chk("midframe_rst_empty", 32'(bus.uart_tx_fifo_empty), 32'd1);
        chk("midframe_rst_byte",  32'(bus.uart_rx_byte),       32'd0);
        repeat (500) @(negedge clk);
        chk("midframe_idle_pin",  32'(bus.uart_tx_pin),        32'd1);
        chk("midframe_ready",     32'(bus.uart_rx_ready),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
